// File: rtl/arch_regfile_commit_if.sv
// ---------------------------------------------------------------------------
// arch_regfile_commit_if
// Purpose: bundles the issue, commit, flush and read-port signals of the
//          architectural register file / rename table into one interface.
// Signals:
//   issue_valid/issue_rd/issue_tag        rename allocation from issue stage
//   commit_valid/commit_idx/commit_data/  ROB head commit stream
//   commit_tag
//   flush                                 discard all speculative renames
//   rs1/rs2                               read addresses
//   rs1_data/rs1_busy/rs1_tag (rs2_*)     operand value or producer tag
//   commit_count                          saturating committed-instr count
// Modports:
//   master  -- the pipeline side (drives issue/commit/reads)
//   slave   -- the register file itself
// ---------------------------------------------------------------------------
interface arch_regfile_commit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 3
);
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [TAG_W-1:0] issue_tag;

  logic             commit_valid;
  logic [4:0]       commit_idx;
  logic [XLEN-1:0]  commit_data;
  logic [TAG_W-1:0] commit_tag;

  logic             flush;

  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             rs1_busy;
  logic             rs2_busy;
  logic [TAG_W-1:0] rs1_tag;
  logic [TAG_W-1:0] rs2_tag;

  logic [15:0]      commit_count;

  modport master (
    output issue_valid, issue_rd, issue_tag,
    output commit_valid, commit_idx, commit_data, commit_tag,
    output flush,
    output rs1, rs2,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, rs1_tag, rs2_tag,
    input  commit_count
  );

  modport slave (
    input  issue_valid, issue_rd, issue_tag,
    input  commit_valid, commit_idx, commit_data, commit_tag,
    input  flush,
    input  rs1, rs2,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, rs1_tag, rs2_tag,
    output commit_count
  );
endinterface

// File: rtl/arch_regfile_commit.sv
// ---------------------------------------------------------------------------
// arch_regfile_commit
// Purpose: architectural register file plus register-status (rename) table.
//          The issue side marks rd busy with the producing ROB tag; the
//          commit side writes committed data and releases busy only when the
//          committing tag still owns rd. Two combinational read ports return
//          operand value, busy flag and producer tag. x0 is hardwired to zero.
// Ports:
//   clk    in  clock
//   rst_n  in  synchronous, active-low reset (priority over all inputs)
//   bus    arch_regfile_commit_if.slave -- issue/commit/flush/read signals
// Configuration:
//   COMMIT_BYPASS_EN  when defined, a same-cycle commit is forwarded to the
//                     read ports (data always; busy/tag release only when the
//                     committing tag owns the register). Undefined: read
//                     ports show registered state only.
// ---------------------------------------------------------------------------
module arch_regfile_commit #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  arch_regfile_commit_if.slave  bus
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [TAG_W-1:0] tags_q [NREG];
  logic [TAG_W-1:0] tags_d [NREG];
  logic [15:0]      count_q;
  logic [15:0]      count_d;

  // -------------------------------------------------------------------------
  // Decoded commit / issue qualifiers
  // -------------------------------------------------------------------------
  logic commit_hit_s;   // commit targets a real (non-x0) register
  logic commit_owns_s;  // committing tag is still the registered owner of rd
  logic issue_hit_s;    // issue allocates a rename this cycle

  // Qualify commit and issue requests against x0 and flush.
  always_comb begin
    commit_hit_s  = bus.commit_valid && (bus.commit_idx != 5'd0);
    commit_owns_s = commit_hit_s
                    && busy_q[bus.commit_idx]
                    && (tags_q[bus.commit_idx] == bus.commit_tag);
    // A flush drops any same-cycle issue.
    issue_hit_s   = bus.issue_valid && (bus.issue_rd != 5'd0) && !bus.flush;
  end

  // -------------------------------------------------------------------------
  // Next-state computation
  // -------------------------------------------------------------------------
  // Build next register file, status table and commit counter.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tags_d = tags_q;

    // Committed data is written regardless of rename ownership or flush.
    if (commit_hit_s) begin
      regs_d[bus.commit_idx] = bus.commit_data;
    end else begin
      regs_d[0] = {XLEN{1'b0}};
    end

    // Release the rename only when the commit comes from the current owner;
    // otherwise a younger writer holds rd and must stay visible.
    if (commit_owns_s) begin
      busy_d[bus.commit_idx] = 1'b0;
      tags_d[bus.commit_idx] = {TAG_W{1'b0}};
    end else begin
      busy_d[0] = 1'b0;
    end

    // Flush wipes every rename; otherwise a new issue overrides any release
    // made above, so issue wins the status when it hits the committing rd.
    if (bus.flush) begin
      busy_d = {NREG{1'b0}};
      for (int i = 0; i < NREG; i++) begin
        tags_d[i] = {TAG_W{1'b0}};
      end
    end else if (issue_hit_s) begin
      busy_d[bus.issue_rd] = 1'b1;
      tags_d[bus.issue_rd] = bus.issue_tag;
    end else begin
      tags_d[0] = {TAG_W{1'b0}};
    end

    // Saturating committed-instruction counter (x0 commits count too).
    if (bus.commit_valid && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // Synchronous active-low reset clears data, status and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
        tags_q[i] <= {TAG_W{1'b0}};
      end
      busy_q  <= {NREG{1'b0}};
      count_q <= 16'd0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
        tags_q[i] <= tags_d[i];
      end
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  logic [4:0] rd_addr_s [2];

  // Map the two interface read addresses onto an indexable pair.
  always_comb begin
    rd_addr_s[0] = bus.rs1;
    rd_addr_s[1] = bus.rs2;
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [XLEN-1:0]  data_s;
    logic             busy_s;
    logic [TAG_W-1:0] tag_s;

    // Look up one read port, with optional commit forwarding and x0 forcing.
    always_comb begin
      data_s = regs_q[rd_addr_s[p]];
      busy_s = busy_q[rd_addr_s[p]];
      // Tag is reported as zero whenever the register is not busy.
      if (busy_q[rd_addr_s[p]]) begin
        tag_s = tags_q[rd_addr_s[p]];
      end else begin
        tag_s = {TAG_W{1'b0}};
      end

`ifdef COMMIT_BYPASS_EN
      // Forward the committing value; release status only for the owner.
      // A same-cycle issue is intentionally never forwarded.
      if (commit_hit_s && (bus.commit_idx == rd_addr_s[p])) begin
        data_s = bus.commit_data;
        if (commit_owns_s) begin
          busy_s = 1'b0;
          tag_s  = {TAG_W{1'b0}};
        end else begin
          busy_s = busy_q[rd_addr_s[p]];
        end
      end else begin
        data_s = data_s;
      end
`endif

      // x0 always reads as zero, never busy.
      if (rd_addr_s[p] == 5'd0) begin
        data_s = {XLEN{1'b0}};
        busy_s = 1'b0;
        tag_s  = {TAG_W{1'b0}};
      end else begin
        busy_s = busy_s;
      end
    end
  end

  assign bus.rs1_data     = g_rd[0].data_s;
  assign bus.rs1_busy     = g_rd[0].busy_s;
  assign bus.rs1_tag      = g_rd[0].tag_s;
  assign bus.rs2_data     = g_rd[1].data_s;
  assign bus.rs2_busy     = g_rd[1].busy_s;
  assign bus.rs2_tag      = g_rd[1].tag_s;
  assign bus.commit_count = count_q;

endmodule

// File: tb/tb_arch_regfile_commit.sv
// ---------------------------------------------------------------------------
// tb_arch_regfile_commit
// Purpose: directed, scoreboard-checked bench for arch_regfile_commit.
//          Stimulus pushes hand-computed expectations tagged with the cycle in
//          which they apply; a monitor on the falling edge pops and compares.
//          Expectations for the commit-bypass cycle follow COMMIT_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_arch_regfile_commit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 3;

  localparam int K_R1D = 0;
  localparam int K_R1B = 1;
  localparam int K_R1T = 2;
  localparam int K_R2D = 3;
  localparam int K_R2B = 4;
  localparam int K_R2T = 5;
  localparam int K_CNT = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  arch_regfile_commit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  arch_regfile_commit #(.XLEN(XLEN), .NREG(32), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    int          cyc;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual_of(input int kind);
    case (kind)
      K_R1D:   return bus.rs1_data;
      K_R1B:   return {31'd0, bus.rs1_busy};
      K_R1T:   return {29'd0, bus.rs1_tag};
      K_R2D:   return bus.rs2_data;
      K_R2B:   return {31'd0, bus.rs2_busy};
      K_R2T:   return {29'd0, bus.rs2_tag};
      K_CNT:   return {16'd0, bus.commit_count};
      default: return 32'hXXXXXXXX;
    endcase
  endfunction

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.name, e.cyc, cyc);
      end else begin
        act = actual_of(e.kind);
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", e.name, act, e.exp, cyc);
        end
      end
    end
  end

  task automatic push(input string name, input int kind, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.cyc  = cyc;
    e.kind = kind;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic exp1(input string name, input logic [31:0] d, input logic b, input logic [2:0] t);
    push({name, ".rs1_data"}, K_R1D, d);
    push({name, ".rs1_busy"}, K_R1B, {31'd0, b});
    push({name, ".rs1_tag"},  K_R1T, {29'd0, t});
  endtask

  task automatic exp2(input string name, input logic [31:0] d, input logic b, input logic [2:0] t);
    push({name, ".rs2_data"}, K_R2D, d);
    push({name, ".rs2_busy"}, K_R2B, {31'd0, b});
    push({name, ".rs2_tag"},  K_R2T, {29'd0, t});
  endtask

  task automatic exp_cnt(input string name, input logic [15:0] c);
    push({name, ".commit_count"}, K_CNT, {16'd0, c});
  endtask

  task automatic drive_idle();
    bus.issue_valid  = 1'b0;
    bus.issue_rd     = 5'd0;
    bus.issue_tag    = 3'd0;
    bus.commit_valid = 1'b0;
    bus.commit_idx   = 5'd0;
    bus.commit_data  = 32'd0;
    bus.commit_tag   = 3'd0;
    bus.flush        = 1'b0;
    bus.rs1          = 5'd0;
    bus.rs2          = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] tag);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = rd;
    bus.issue_tag   = tag;
  endtask

  task automatic commit(input logic [4:0] idx, input logic [2:0] tag, input logic [31:0] d);
    bus.commit_valid = 1'b1;
    bus.commit_idx   = idx;
    bus.commit_tag   = tag;
    bus.commit_data  = d;
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (2) step();

    // Reset state; issue rd5/tag3 in the same cycle.
    rst_n   = 1'b1;
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd0;
    exp1("reset_rs1", 32'd0, 1'b0, 3'd0);
    exp2("reset_rs2", 32'd0, 1'b0, 3'd0);
    exp_cnt("reset", 16'd0);
    issue(5'd5, 3'd3);
    step();

    drive_idle();
    bus.rs1 = 5'd5;
    exp1("issue5", 32'd0, 1'b1, 3'd3);
    step();

    drive_idle();
    bus.rs1 = 5'd5;
    commit(5'd5, 3'd3, 32'hDEADBEEF);
`ifdef COMMIT_BYPASS_EN
    exp1("commit5_same", 32'hDEADBEEF, 1'b0, 3'd0);
`else
    exp1("commit5_same", 32'd0, 1'b1, 3'd3);
`endif
    step();

    drive_idle();
    bus.rs1 = 5'd5;
    exp1("commit5", 32'hDEADBEEF, 1'b0, 3'd0);
    exp_cnt("commit5", 16'd1);
    step();

    // Older commit must not release a younger rename.
    drive_idle();
    issue(5'd7, 3'd1);
    step();
    drive_idle();
    issue(5'd7, 3'd4);
    step();
    drive_idle();
    bus.rs1 = 5'd7;
    commit(5'd7, 3'd1, 32'h11);
`ifdef COMMIT_BYPASS_EN
    exp1("stale7_same", 32'h11, 1'b1, 3'd4);
`else
    exp1("stale7_same", 32'd0, 1'b1, 3'd4);
`endif
    step();
    drive_idle();
    bus.rs1 = 5'd7;
    exp1("stale7", 32'h11, 1'b1, 3'd4);
    step();
    drive_idle();
    commit(5'd7, 3'd4, 32'h22);
    step();
    drive_idle();
    bus.rs1 = 5'd7;
    exp1("owner7", 32'h22, 1'b0, 3'd0);
    exp_cnt("owner7", 16'd3);
    step();

    // Same-cycle issue and commit to rd9: data written, issue wins status.
    drive_idle();
    issue(5'd9, 3'd6);
    commit(5'd9, 3'd2, 32'h55);
    step();
    drive_idle();
    bus.rs1 = 5'd9;
    exp1("collide9", 32'h55, 1'b1, 3'd6);
    exp_cnt("collide9", 16'd4);
    step();

    // x0 issue/commit ignored, but the commit still counts.
    drive_idle();
    issue(5'd0, 3'd7);
    commit(5'd0, 3'd0, 32'hFF);
    exp1("x0_same", 32'd0, 1'b0, 3'd0);
    exp2("x0_same", 32'd0, 1'b0, 3'd0);
    step();
    drive_idle();
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd9;
    exp1("x0", 32'd0, 1'b0, 3'd0);
    exp2("keep9", 32'h55, 1'b1, 3'd6);
    exp_cnt("x0", 16'd5);
    step();

    // Flush with regs 3,4 busy, same-cycle issue rd8 and commit to rd3.
    drive_idle();
    issue(5'd3, 3'd1);
    step();
    drive_idle();
    issue(5'd4, 3'd2);
    step();
    drive_idle();
    bus.rs1 = 5'd3;
    bus.rs2 = 5'd4;
    exp1("preflush3", 32'd0, 1'b1, 3'd1);
    exp2("preflush4", 32'd0, 1'b1, 3'd2);
    step();
    drive_idle();
    bus.flush = 1'b1;
    issue(5'd8, 3'd5);
    commit(5'd3, 3'd1, 32'h33);
    step();
    drive_idle();
    bus.rs1 = 5'd3;
    bus.rs2 = 5'd4;
    exp1("flush3", 32'h33, 1'b0, 3'd0);
    exp2("flush4", 32'd0, 1'b0, 3'd0);
    exp_cnt("flush", 16'd6);
    step();
    drive_idle();
    bus.rs1 = 5'd8;
    bus.rs2 = 5'd9;
    exp1("flush8", 32'd0, 1'b0, 3'd0);
    exp2("flush9", 32'h55, 1'b0, 3'd0);
    step();

    // Issue and commit to different registers in the same cycle.
    drive_idle();
    issue(5'd11, 3'd2);
    step();
    drive_idle();
    issue(5'd10, 3'd3);
    commit(5'd11, 3'd2, 32'h77);
    step();
    drive_idle();
    bus.rs1 = 5'd10;
    bus.rs2 = 5'd11;
    exp1("indep10", 32'd0, 1'b1, 3'd3);
    exp2("indep11", 32'h77, 1'b0, 3'd0);
    exp_cnt("indep", 16'd7);
    step();

    // Commit visibility on the read port in the commit cycle.
    drive_idle();
    issue(5'd12, 3'd5);
    step();
    drive_idle();
    bus.rs1 = 5'd12;
    exp1("issue12", 32'd0, 1'b1, 3'd5);
    step();
    drive_idle();
    bus.rs1 = 5'd12;
    commit(5'd12, 3'd5, 32'hABCD);
`ifdef COMMIT_BYPASS_EN
    exp1("bypass12", 32'hABCD, 1'b0, 3'd0);
`else
    exp1("bypass12", 32'd0, 1'b1, 3'd5);
`endif
    step();
    drive_idle();
    bus.rs1 = 5'd12;
    exp1("commit12", 32'hABCD, 1'b0, 3'd0);
    exp_cnt("commit12", 16'd8);
    step();

    // Counter saturation: 65527 more commits take it from 8 to 0xFFFF.
    drive_idle();
    commit(5'd0, 3'd0, 32'd0);
    repeat (65527) step();
    exp_cnt("sat_reach", 16'hFFFF);
    step();
    exp_cnt("sat_hold", 16'hFFFF);
    drive_idle();
    step();
    exp_cnt("sat_idle", 16'hFFFF);
    repeat (2) step();

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
